// File: rtl/gmii_to_axi.sv
// GMII receive byte stream to 64-bit AXI-Stream beats: optional preamble strip,
// bad-frame tagging on tuser and a word FIFO that keeps one slot for a terminating beat.
module gmii_to_axi #(
    parameter int STRIP_PREAMBLE = 1,
    parameter int FIFO_DEPTH     = 16,
    parameter int MAX_BYTES      = 1536
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    input  logic        axis_tready,
    output logic        axis_tvalid,
    output logic [63:0] axis_tdata,
    output logic [7:0]  axis_tkeep,
    output logic        axis_tlast,
    output logic        axis_tuser,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);
    // state    | meaning
    // ST_IDLE  | waiting for dv
    // ST_PRE   | discarding 0x55 bytes until the 0xD5 SFD
    // ST_DATA  | packing payload bytes into 64-bit words
    // ST_DROP  | frame rejected or already terminated, waiting for dv low
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_BYTES + 1);

    logic          dv_q, er_q;
    logic [7:0]    rxd_q;
    state_t        state, state_d;
    logic [63:0]   pack, hold;
    logic          hold_vld;
    logic [2:0]    byte_cnt;
    logic          err;
    logic [BW-1:0] bytes_left;

    logic          push, push_last, push_user;
    logic [63:0]   push_data;
    logic [7:0]    push_keep, keep_part;
    logic          byte_wr, hold_pop, clr, pre_rej;

    logic [73:0]   mem [FIFO_DEPTH];
    logic [73:0]   rd_word;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          wr, rd, room2;

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
            rxd_q <= 8'd0;
        end else begin
            dv_q  <= gmii_rx_dv;
            er_q  <= gmii_rx_er;
            rxd_q <= gmii_rxd;
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    assign keep_part = 8'hFF >> (4'd8 - {1'b0, byte_cnt});
    assign room2     = (count <= CW'(FIFO_DEPTH - 2));

    always_comb begin
        state_d   = state;
        push      = 1'b0;
        push_data = hold;
        push_keep = 8'hFF;
        push_last = 1'b0;
        push_user = 1'b0;
        byte_wr   = 1'b0;
        hold_pop  = 1'b0;
        pre_rej   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dv_q) begin
                    if (STRIP_PREAMBLE != 0) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d = ST_DATA;
                        byte_wr = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (!dv_q || (rxd_q != 8'h55 && rxd_q != 8'hD5)) begin
                    state_d = ST_DROP;
                    pre_rej = 1'b1;
                end else if (rxd_q == 8'hD5) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (dv_q) begin
                    if (bytes_left == '0) begin
                        // Over-length: whatever is pending becomes a bad final beat.
                        state_d   = ST_DROP;
                        push_last = 1'b1;
                        push_user = 1'b1;
                        if (hold_vld) begin
                            push = 1'b1;
                        end else if (byte_cnt != 3'd0) begin
                            push      = 1'b1;
                            push_data = pack;
                            push_keep = keep_part;
                        end
                    end else if (hold_vld) begin
                        push = 1'b1;
                        if (room2) begin
                            hold_pop = 1'b1;
                            byte_wr  = 1'b1;
                        end else begin
                            // Last free slot: terminate the frame instead of continuing it.
                            push_last = 1'b1;
                            push_user = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end else begin
                        byte_wr = 1'b1;
                    end
                end else begin
                    state_d   = ST_IDLE;
                    push_last = 1'b1;
                    push_user = err;
                    if (hold_vld) begin
                        push = 1'b1;
                    end else if (byte_cnt != 3'd0) begin
                        push      = 1'b1;
                        push_data = pack;
                        push_keep = keep_part;
                    end
                end
            end
            ST_DROP: begin
                if (!dv_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clr = (state_d != ST_DATA);

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            pack       <= 64'd0;
            hold       <= 64'd0;
            hold_vld   <= 1'b0;
            byte_cnt   <= 3'd0;
            err        <= 1'b0;
            bytes_left <= BW'(MAX_BYTES);
        end else if (clr) begin
            pack       <= 64'd0;
            hold_vld   <= 1'b0;
            byte_cnt   <= 3'd0;
            err        <= 1'b0;
            bytes_left <= BW'(MAX_BYTES);
        end else if (byte_wr) begin
            byte_cnt   <= byte_cnt + 3'd1;
            bytes_left <= bytes_left - BW'(1);
            err        <= err | er_q;
            if (byte_cnt == 3'd7) begin
                hold     <= {rxd_q, pack[55:0]};
                hold_vld <= 1'b1;
                pack     <= 64'd0;
            end else begin
                pack[{byte_cnt, 3'b000} +: 8] <= rxd_q;
                if (hold_pop) hold_vld <= 1'b0;
            end
        end
    end

    assign wr = push && (count != CW'(FIFO_DEPTH));
    assign rd = (count != '0) && axis_tready;

    always_ff @(posedge gmii_rx_clk) begin
        if (wr) mem[wr_ptr] <= {push_user, push_last, push_keep, push_data};
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
            err_cnt   <= 16'd0;
        end else begin
            if (wr && push_last && !push_user && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'd1;
            if ((pre_rej || (wr && push_last && push_user)) && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

    assign rd_word     = mem[rd_ptr];
    assign axis_tvalid = (count != '0);
    assign axis_tdata  = axis_tvalid ? rd_word[63:0]  : 64'd0;
    assign axis_tkeep  = axis_tvalid ? rd_word[71:64] : 8'd0;
    assign axis_tlast  = axis_tvalid && rd_word[72];
    assign axis_tuser  = axis_tvalid && rd_word[73];

endmodule

// File: tb/tb_gmii_to_axi.sv
// Directed bench for gmii_to_axi: preamble strip, packing, error tagging, preamble
// reject, FIFO-full termination, truncation and mid-frame reset.
module tb_gmii_to_axi;
    logic        gmii_rx_clk = 1'b0;
    logic        rst_n, gmii_rx_dv, gmii_rx_er, axis_tready;
    logic [7:0]  gmii_rxd;
    logic        axis_tvalid, axis_tlast, axis_tuser;
    logic [63:0] axis_tdata;
    logic [7:0]  axis_tkeep;
    logic [15:0] frame_cnt, err_cnt;

    always #4 gmii_rx_clk = ~gmii_rx_clk;

    gmii_to_axi #(.STRIP_PREAMBLE(1), .FIFO_DEPTH(4), .MAX_BYTES(64)) dut (
        .gmii_rx_clk (gmii_rx_clk),
        .rst_n       (rst_n),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .gmii_rxd    (gmii_rxd),
        .axis_tready (axis_tready),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tuser  (axis_tuser),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];
    logic        q_user[$];

    always @(negedge gmii_rx_clk) begin
        if (rst_n && axis_tvalid && axis_tready) begin
            q_data.push_back(axis_tdata);
            q_keep.push_back(axis_tkeep);
            q_last.push_back(axis_tlast);
            q_user.push_back(axis_tuser);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clrq();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        q_user.delete();
    endtask

    function automatic logic [63:0] exp_word(input logic [7:0] start, input int j);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[b*8 +: 8] = start + 8'(8*j + b);
        return w;
    endfunction

    task automatic chk_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                            input logic l, input logic u);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{k[b]}};
        chk({tag, "_avail"}, 64'(q_data.size() > 0), 64'd1);
        if (q_data.size() > 0) begin
            chk({tag, "_data"}, q_data[0] & m, d);
            chk({tag, "_keep"}, 64'(q_keep[0]), 64'(k));
            chk({tag, "_last"}, 64'(q_last[0]), 64'(l));
            chk({tag, "_user"}, 64'(q_user[0]), 64'(u));
            void'(q_data.pop_front());
            void'(q_keep.pop_front());
            void'(q_last.pop_front());
            void'(q_user.pop_front());
        end
    endtask

    task automatic put(input logic [7:0] d, input logic e);
        @(negedge gmii_rx_clk);
        gmii_rx_dv = 1'b1;
        gmii_rxd   = d;
        gmii_rx_er = e;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge gmii_rx_clk);
            gmii_rx_dv = 1'b0;
            gmii_rx_er = 1'b0;
            gmii_rxd   = 8'd0;
        end
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
        put(8'hD5, 1'b0);
    endtask

    task automatic send_frame(input int len, input logic [7:0] start, input int er_idx);
        preamble();
        for (int i = 0; i < len; i++) put(start + 8'(i), i == er_idx);
        gap(12);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'd0; axis_tready = 1'b1;
        repeat (3) @(negedge gmii_rx_clk);
        #1;
        chk("rst_tvalid", 64'(axis_tvalid), 64'd0);
        chk("rst_tdata", axis_tdata, 64'd0);
        chk("rst_tkeep", 64'(axis_tkeep), 64'd0);
        chk("rst_tlast", 64'(axis_tlast), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge gmii_rx_clk);
        rst_n = 1'b1;
        gap(4);

        // 16-byte aligned frame
        clrq();
        send_frame(16, 8'h01, -1);
        chk("t1_nbeats", 64'(q_data.size()), 64'd2);
        chk_beat("t1_b0", 64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
        chk_beat("t1_b1", 64'h100F0E0D0C0B0A09, 8'hFF, 1'b1, 1'b0);
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t1_err_cnt", 64'(err_cnt), 64'd0);

        // 11-byte frame, partial last beat
        clrq();
        send_frame(11, 8'h01, -1);
        chk("t2_nbeats", 64'(q_data.size()), 64'd2);
        chk_beat("t2_b0", 64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
        chk_beat("t2_b1", 64'h00000000000B0A09, 8'h07, 1'b1, 1'b0);
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);

        // rx_er inside a 64-byte frame
        clrq();
        send_frame(64, 8'h01, 5);
        chk("t3_nbeats", 64'(q_data.size()), 64'd8);
        for (int j = 0; j < 8; j++)
            chk_beat($sformatf("t3_b%0d", j), exp_word(8'h01, j), 8'hFF, j == 7, j == 7);
        chk("t3_err_cnt", 64'(err_cnt), 64'd1);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd2);

        // bad preamble byte, then a good frame
        clrq();
        put(8'h55, 1'b0); put(8'h55, 1'b0); put(8'hAA, 1'b0);
        for (int i = 0; i < 20; i++) put(8'h5A + 8'(i), 1'b0);
        gap(12);
        #1;
        chk("t4_nbeats_rej", 64'(q_data.size()), 64'd0);
        chk("t4_err_cnt", 64'(err_cnt), 64'd2);
        send_frame(16, 8'h21, -1);
        chk("t4_nbeats_good", 64'(q_data.size()), 64'd2);
        chk_beat("t4_b0", exp_word(8'h21, 0), 8'hFF, 1'b0, 1'b0);
        chk_beat("t4_b1", exp_word(8'h21, 1), 8'hFF, 1'b1, 1'b0);
        chk("t4_frame_cnt", 64'(frame_cnt), 64'd3);

        // backpressure fills the 4-deep FIFO
        clrq();
        axis_tready = 1'b0;
        send_frame(64, 8'h01, -1);
        chk("t5_nbeats_blocked", 64'(q_data.size()), 64'd0);
        chk("t5_tvalid_blocked", 64'(axis_tvalid), 64'd1);
        chk("t5_tdata_stable", axis_tdata, 64'h0807060504030201);
        chk("t5_err_cnt", 64'(err_cnt), 64'd3);
        @(negedge gmii_rx_clk);
        axis_tready = 1'b1;
        gap(8);
        #1;
        chk("t5_nbeats", 64'(q_data.size()), 64'd4);
        for (int j = 0; j < 4; j++)
            chk_beat($sformatf("t5_b%0d", j), exp_word(8'h01, j), 8'hFF, j == 3, j == 3);
        chk("t5_tvalid_drained", 64'(axis_tvalid), 64'd0);
        send_frame(16, 8'h41, -1);
        chk("t5_next_nbeats", 64'(q_data.size()), 64'd2);
        chk_beat("t5_next_b0", exp_word(8'h41, 0), 8'hFF, 1'b0, 1'b0);
        chk_beat("t5_next_b1", exp_word(8'h41, 1), 8'hFF, 1'b1, 1'b0);
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd4);

        // 70 bytes against a 64-byte limit
        clrq();
        send_frame(70, 8'h01, -1);
        chk("t6_nbeats", 64'(q_data.size()), 64'd8);
        for (int j = 0; j < 8; j++)
            chk_beat($sformatf("t6_b%0d", j), exp_word(8'h01, j), 8'hFF, j == 7, j == 7);
        chk("t6_err_cnt", 64'(err_cnt), 64'd4);
        chk("t6_frame_cnt", 64'(frame_cnt), 64'd4);

        // reset in the middle of a frame
        clrq();
        axis_tready = 1'b0;
        preamble();
        for (int i = 0; i < 13; i++) put(8'h01 + 8'(i), 1'b0);
        #1;
        chk("t7_tvalid_before", 64'(axis_tvalid), 64'd1);
        rst_n = 1'b0;
        gmii_rx_dv = 1'b0;
        #1;
        chk("t7_tvalid_in_rst", 64'(axis_tvalid), 64'd0);
        @(negedge gmii_rx_clk);
        #1;
        chk("t7_tvalid_next", 64'(axis_tvalid), 64'd0);
        chk("t7_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t7_err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        axis_tready = 1'b1;
        clrq();
        gap(20);
        #1;
        chk("t7_no_stale", 64'(q_data.size()), 64'd0);
        send_frame(16, 8'h61, -1);
        chk("t7_nbeats", 64'(q_data.size()), 64'd2);
        chk_beat("t7_b0", exp_word(8'h61, 0), 8'hFF, 1'b0, 1'b0);
        chk_beat("t7_b1", exp_word(8'h61, 1), 8'hFF, 1'b1, 1'b0);
        chk("t7_frame_cnt_after", 64'(frame_cnt), 64'd1);
        chk("t7_err_cnt_after", 64'(err_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
